// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, size codes and lane helpers for the data-memory access unit
//
// Purpose: FSM state encoding, MemSize codes and the alignment / store-lane
// helpers used by mem_access and mem_load_fmt.
// Ports: none (package).

package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // The reserved size code 2'b11 falls into the word case everywhere.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~addr_lo[0];
      default: is_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: store_be = 4'b0001 << addr_lo;
      SZ_HALF: store_be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Data is replicated across lanes so the byte enables alone pick the target.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: store_wdata = {4{wd[7:0]}};
      SZ_HALF: store_wdata = {2{wd[15:0]}};
      default: store_wdata = wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// rtl/mem_load_fmt.sv - load lane selection and sign/zero extension
//
// Purpose: pick the addressed byte/half lane out of a memory word and extend
// it to 32 bits; word loads pass through unchanged.
// Ports:
//   rdata    in  [31:0] raw word from memory
//   size     in  [1:0]  access size code (SZ_*)
//   sign_ext in         1 = sign-extend, 0 = zero-extend
//   addr_lo  in  [1:0]  byte offset within the word
//   data     out [31:0] formatted load value

module mem_load_fmt
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      SZ_HALF: data = {{16{sign_ext & half_lane[15]}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - M-stage data-memory access unit with stall, timeout and misalign detection
//
// Purpose: turns the M-stage load/store into a req/ack memory transaction,
// stalls the pipeline while it is outstanding and formats load data.
// Ports:
//   clk, rst                  clock, async active-high reset
//   MemReadM/MemWriteM        load / store request (store wins if both)
//   MemSizeM, MemSignedM      access size and load extension
//   ALUResultM, WriteDataM    byte address and right-justified store data
//   ReadDataM                 registered formatted load result
//   StallM, MisalignM         pipeline stall, combinational misalign flag
//   BusErrM                   one-cycle pulse on memory timeout
//   dmem_req/we/addr/wdata/be registered memory request
//   dmem_rdata, dmem_ack      memory response

module mem_access
  import mem_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignedM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int CW = $clog2(DMEM_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DMEM_TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  // Attributes of the accepted access, kept for formatting the returned data.
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  lo_q, lo_d;
  logic        load_q, load_d;

  logic        access;
  logic        aligned;
  logic        valid;
  logic [31:0] fmt_data;

  mem_load_fmt u_fmt (
    .rdata    (dmem_rdata),
    .size     (size_q),
    .sign_ext (sign_q),
    .addr_lo  (lo_q),
    .data     (fmt_data)
  );

  assign access  = MemReadM | MemWriteM;
  assign aligned = is_aligned(MemSizeM, ALUResultM[1:0]);
  assign valid   = access & aligned;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    bus_err_d  = 1'b0;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    size_d     = size_q;
    sign_d     = sign_q;
    lo_d       = lo_q;
    load_d     = load_q;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
          req_d      = 1'b1;
          we_d       = MemWriteM;
          addr_d     = {ALUResultM[31:2], 2'b00};
          be_d       = store_be(MemSizeM, ALUResultM[1:0]);
          wdata_d    = store_wdata(MemSizeM, WriteDataM);
          size_d     = MemSizeM;
          sign_d     = MemSignedM;
          lo_d       = ALUResultM[1:0];
          load_d     = MemReadM & ~MemWriteM;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          if (load_q) rdata_d = fmt_data;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d   = ST_DONE;
          req_d     = 1'b0;
          rdata_d   = '0;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      size_q     <= SZ_WORD;
      sign_q     <= 1'b0;
      lo_q       <= 2'b00;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      lo_q       <= lo_d;
      load_q     <= load_d;
    end
  end

  // DONE releases the stall so the pipeline advances on that edge.
  assign StallM     = ~rst & (((state_q == ST_IDLE) & valid) | (state_q == ST_WAIT));
  assign MisalignM  = ~rst & (state_q == ST_IDLE) & access & ~aligned;
  assign ReadDataM  = rdata_q;
  assign BusErrM    = bus_err_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access

module tb_mem_access;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM, MemSignedM;
  logic [1:0]  MemSizeM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, BusErrM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;

  mem_access #(.DMEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
    .MemSignedM(MemSignedM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Expected outputs for the current cycle, maintained by the stimulus.
  bit          exp_stall, exp_mis, exp_req, exp_berr, chk_bus, exp_we;
  logic [31:0] exp_addr, exp_wdata, rd_model;
  logic [3:0]  exp_be;
  int          stall_seen, req_seen, berr_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_aligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b10) return 1'b1;
    if (sz == 2'b01) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b10) return 4'(1 << (a % 4));
    if (sz == 2'b01) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b10) return 32'h01010101 * (wd & 32'hFF);
    if (sz == 2'b01) return 32'h00010001 * (wd & 32'hFFFF);
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg,
                                         input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    if (sz == 2'b10) begin
      v = (d >> (8 * (a % 4))) & 32'hFF;
      if (sg && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = (d >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (sg && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    chk("stall", 32'(StallM), 32'(exp_stall));
    chk("misalign", 32'(MisalignM), 32'(exp_mis));
    chk("req", 32'(dmem_req), 32'(exp_req));
    chk("buserr", 32'(BusErrM), 32'(exp_berr));
    chk("readdata", ReadDataM, rd_model);
    if (chk_bus) begin
      chk("addr", dmem_addr, exp_addr);
      chk("we", 32'(dmem_we), 32'(exp_we));
      chk("be", 32'(dmem_be), 32'(exp_be));
      chk("wdata", dmem_wdata, exp_wdata);
    end
    if (StallM) stall_seen++;
    if (dmem_req) req_seen++;
    if (BusErrM) berr_seen++;
  end

  task automatic stray();
    dmem_ack   = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
  endtask

  task automatic set_idle_exp();
    exp_stall = 0; exp_mis = 0; exp_req = 0; exp_berr = 0; chk_bus = 0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    MemReadM = 0; MemWriteM = 0; MemSizeM = $urandom; MemSignedM = $urandom;
    ALUResultM = $urandom; WriteDataM = $urandom;
    stray();
    set_idle_exp();
  endtask

  task automatic settle_clear();
    @(negedge clk); #1;
    stall_seen = 0; req_seen = 0; berr_seen = 0;
  endtask

  // ack_k: WAIT cycle (1-based) in which ack arrives; 0 = never (timeout).
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int ack_k, input logic [31:0] rdat);
    bit valid;
    int n;
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; MemSizeM = sz; MemSignedM = sg;
    ALUResultM = a; WriteDataM = wd;
    stray();
    valid = (rd || wr) && m_aligned(sz, a);
    exp_stall = valid; exp_mis = (rd || wr) && !valid;
    exp_req = 0; exp_berr = 0; chk_bus = 0;
    if (!valid) return;
    exp_addr  = a & ~32'd3;
    exp_we    = wr;
    exp_be    = m_be(sz, a);
    exp_wdata = m_wdata(sz, wd);
    n = (ack_k > 0) ? ack_k : T;
    for (int j = 1; j <= n; j++) begin
      @(posedge clk); #1;
      dmem_ack   = (j == ack_k);
      dmem_rdata = (j == ack_k) ? rdat : $urandom;
      exp_stall = 1; exp_req = 1; exp_mis = 0; chk_bus = 1;
    end
    @(posedge clk); #1;
    stray();
    if (ack_k == 0) begin
      rd_model = 0;
      exp_berr = 1;
    end else if (rd && !wr) begin
      rd_model = m_load(sz, sg, a, rdat);
    end
    exp_stall = 0; exp_req = 0; exp_mis = 0; chk_bus = 0;
  endtask

  initial begin
    rst = 1;
    MemReadM = 1; MemWriteM = 0; MemSizeM = 2'b00; MemSignedM = 0;
    ALUResultM = 32'h100; WriteDataM = 0; dmem_rdata = 0; dmem_ack = 0;
    rd_model = 0; exp_addr = 0; exp_wdata = 0; exp_be = 0; exp_we = 0;
    set_idle_exp();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_readdata", ReadDataM, 32'h0);
    chk("reset_req", 32'(dmem_req), 32'h0);
    chk("reset_stall", 32'(StallM), 32'h0);
    rst = 0;
    MemReadM = 0;
    idle_cycle();

    // Load word, ack in second WAIT cycle.
    settle_clear();
    do_access(1, 0, 2'b00, 0, 32'h100, 0, 2, 32'hDEADBEEF);
    settle_clear_check_037: begin
      @(negedge clk); #1;
      chk("ld_word_data", ReadDataM, 32'hDEADBEEF);
      chk("ld_word_stalls", stall_seen, 3);
    end
    // Zero-wait memory: two stall cycles.
    idle_cycle();
    settle_clear();
    do_access(1, 0, 2'b00, 0, 32'h104, 0, 1, 32'h11111111);
    @(negedge clk); #1;
    chk("zero_wait_stalls", stall_seen, 2);
    chk("zero_wait_data", ReadDataM, 32'h11111111);

    do_access(1, 0, 2'b10, 1, 32'h103, 0, 1, 32'h80112233);
    @(negedge clk); #1;
    chk("ld_byte_signed", ReadDataM, 32'hFFFFFF80);
    do_access(1, 0, 2'b10, 0, 32'h103, 0, 1, 32'h80112233);
    @(negedge clk); #1;
    chk("ld_byte_unsigned", ReadDataM, 32'h00000080);

    do_access(0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 1, 32'hFFFFFFFF);
    @(negedge clk); #1;
    chk("st_half_be", 32'(dmem_be), 32'hC);
    chk("st_half_wdata", dmem_wdata, 32'hABCDABCD);
    chk("st_half_addr", dmem_addr, 32'h200);
    chk("st_keeps_readdata", ReadDataM, 32'h00000080);

    // Load and store together: store wins, ReadDataM untouched.
    do_access(1, 1, 2'b00, 0, 32'h300, 32'h55, 1, 32'h12345678);
    @(negedge clk); #1;
    chk("both_we", 32'(dmem_we), 32'h1);
    chk("both_readdata", ReadDataM, 32'h00000080);

    idle_cycle();
    settle_clear();
    do_access(1, 0, 2'b00, 0, 32'h101, 0, 1, 32'h0);
    #2;
    chk("misalign_flag", 32'(MisalignM), 32'h1);
    chk("misalign_stall", 32'(StallM), 32'h0);
    @(negedge clk); #1;
    chk("misalign_req_cycles", req_seen, 0);

    idle_cycle();
    settle_clear();
    do_access(1, 0, 2'b00, 0, 32'h400, 0, 0, 32'h0);
    @(negedge clk); #1;
    chk("timeout_req_cycles", req_seen, T);
    chk("timeout_berr_pulses", berr_seen, 1);
    chk("timeout_readdata", ReadDataM, 32'h0);

    // Reset in mid-WAIT followed by a stray ack.
    do_access(1, 0, 2'b00, 0, 32'h500, 0, 1, 32'hCAFEF00D);
    @(posedge clk); #1;
    MemReadM = 1; MemWriteM = 0; MemSizeM = 2'b00; ALUResultM = 32'h100; dmem_ack = 0;
    exp_stall = 1; exp_mis = 0; exp_req = 0; exp_berr = 0; chk_bus = 0;
    exp_addr = 32'h100; exp_we = 0; exp_be = 4'hF; exp_wdata = m_wdata(2'b00, WriteDataM);
    @(posedge clk); #1;
    exp_req = 1; chk_bus = 1;
    @(negedge clk); #1;
    rst = 1;
    rd_model = 0;
    set_idle_exp();
    #1;
    chk("rst_wait_req", 32'(dmem_req), 32'h0);
    chk("rst_wait_stall", 32'(StallM), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    MemReadM = 0;
    @(posedge clk); #1;
    dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk); #1;
    chk("late_ack_readdata", ReadDataM, 32'h0);
    chk("late_ack_req", 32'(dmem_req), 32'h0);
    dmem_ack = 0;

    for (int i = 0; i < 300; i++) begin
      int op;
      int ak;
      op = $urandom_range(0, 3);
      ak = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, T);
      if (op == 0) idle_cycle();
      else do_access(op[0], op[1], 2'($urandom), 1'($urandom), $urandom, $urandom, ak, $urandom);
    end
    idle_cycle();
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter DMEM_TIMEOUT, default 16: the maximum number of WAIT cycles without dmem_ack before a bus error is declared.
REQ-002 SHALL have clk, input, 1: the single pipeline clock.
REQ-003 SHALL have rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have MemReadM, input, 1: the M-stage instruction is a load.
REQ-005 SHALL have MemWriteM, input, 1: the M-stage instruction is a store.
REQ-006 SHALL have MemSizeM, input, 2: access size; 00 word, 01 half, 10 byte, 11 reserved (treated as word).
REQ-007 SHALL have MemSignedM, input, 1: 1 sign-extends half/byte loads, 0 zero-extends them.
REQ-008 SHALL have ALUResultM, input, 32: byte address.
REQ-009 SHALL have WriteDataM, input, 32: store data, right-justified.
REQ-010 SHALL have ReadDataM, output, 32: the registered, formatted load result, fed to the M/W register.
REQ-011 SHALL have StallM, output, 1: freezes PC and all upstream pipeline registers and holds M/W.
REQ-012 SHALL have MisalignM, output, 1: combinational; the current access is misaligned.
REQ-013 SHALL have BusErrM, output, 1: registered one-cycle pulse on timeout.
REQ-014 SHALL have dmem_req/dmem_we, output, 1 each: request strobe and write enable.
REQ-015 SHALL have dmem_addr, output, 32: word-aligned address, with bits [1:0] = 00.
REQ-016 SHALL have dmem_wdata, output, 32, and dmem_be, output, 4: lane-replicated data and byte enables.
REQ-017 SHALL have dmem_rdata, input, 32, and dmem_ack, input, 1: the memory's response.

Function
REQ-018 SHALL implement the FSM IDLE -> WAIT -> DONE -> IDLE.
REQ-019 SHALL treat an access as valid when (MemReadM|MemWriteM) is 1 and the address is aligned.
- Word aligned: addr[1:0]=00.
- Half aligned: addr[0]=0.
- Byte: always aligned.
REQ-020 SHALL, in IDLE with a valid access:
- drive StallM=1 combinationally;
- register dmem_addr, dmem_we, dmem_be and dmem_wdata;
- go to WAIT.
REQ-021 SHALL, in WAIT, hold dmem_req=1, StallM=1 and all dmem_* outputs stable, and increment a wait counter.
REQ-022 SHALL, on dmem_ack=1 in WAIT:
- drop dmem_req on the next edge;
- for a load, register the formatted dmem_rdata into ReadDataM;
- go to DONE.
REQ-023 SHALL drive StallM=0 in DONE, so the pipeline advances at that edge, and SHALL NOT start a new request in DONE.
REQ-024 SHALL give a zero-wait memory (ack in the first WAIT cycle) a total occupancy of 3 cycles, with 2 stall cycles.
REQ-025 SHALL, when the wait counter reaches DMEM_TIMEOUT with no ack:
- drop dmem_req;
- set ReadDataM=0;
- pulse BusErrM for one cycle;
- go to DONE.
REQ-026 SHALL, on a misaligned access in IDLE:
- issue no request;
- drive MisalignM=1 and StallM=0;
- leave ReadDataM unchanged;
- stay in IDLE.
REQ-027 SHALL give a store priority when MemReadM and MemWriteM are both 1, and SHALL NOT update ReadDataM in that case.
REQ-028 SHALL generate store byte enables as follows:
- byte: be = 0001 << addr[1:0], with wdata = {4{WriteDataM[7:0]}};
- half: be = addr[1] ? 1100 : 0011, with wdata = {2{WriteDataM[15:0]}};
- word: be = 1111.
REQ-029 SHALL format loads by selecting the addressed lane and extending it to 32 bits per MemSignedM; a word load is passed through unchanged.
REQ-030 SHALL ignore dmem_ack outside WAIT.
REQ-031 SHALL hold ReadDataM at its last value for non-load instructions.

Reset
REQ-032 SHALL, on rst=1 and irrespective of clk:
- force state IDLE;
- clear the wait counter;
- set ReadDataM=0, BusErrM=0 and dmem_req=0, and clear dmem_we, dmem_addr, dmem_wdata and dmem_be.
REQ-033 SHALL abandon any outstanding access when rst asserts mid-WAIT, and SHALL ignore a late ack arriving after reset release.
REQ-034 SHALL drive StallM=0 and MisalignM=0 while rst=1.

Structure
REQ-035 SHALL place the FSM state encoding and the MemSize codes (SZ_WORD, SZ_HALF, SZ_BYTE) in the shared package mem_pkg.
REQ-036 SHALL implement load lane selection and extension in one combinational sub-module, mem_load_fmt.

Verification
REQ-037 SHALL cover a load word, addr 0x100, with ack after 2 WAIT cycles -> StallM high for 3 cycles; ReadDataM=dmem_rdata=0xDEADBEEF in DONE.
REQ-038 SHALL cover a load byte, signed, addr 0x103, rdata 0x80112233 -> ReadDataM=0xFFFFFF80; the unsigned case -> 0x00000080.
REQ-039 SHALL cover a store half, addr 0x202, WriteDataM 0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200.
REQ-040 SHALL cover a load word at addr 0x101 -> MisalignM=1, StallM=0, dmem_req never asserted.
REQ-041 SHALL cover a load with no ack and DMEM_TIMEOUT=4 -> dmem_req drops after 4 WAIT cycles; BusErrM pulses once; ReadDataM=0.
REQ-042 SHALL cover rst asserted in WAIT followed by a stray ack -> state IDLE, dmem_req=0, ReadDataM=0 unchanged by the ack.
